// File: rtl/mcoi_led_driver.sv
// Multi-channel front-panel LED driver: per-channel off/on/blink/event-stretch,
// driven from one shared tick prescaler and one shared blink phase.
module mcoi_led_driver #(
    parameter int unsigned NUM_LEDS         = 3,
    parameter int unsigned CLK_FREQ_HZ      = 100000000,
    parameter int unsigned TICK_HZ          = 1000,
    parameter int unsigned BLINK_HALF_TICKS = 100,
    parameter int unsigned STRETCH_TICKS    = 50,
    parameter bit          INVERT           = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [2*NUM_LEDS-1:0] mode_ib,
    input  logic [NUM_LEDS-1:0]   event_i,
    output logic [NUM_LEDS-1:0]   led_o,
    output logic                  tick_o
);
    localparam int unsigned DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BLK_W = (BLINK_HALF_TICKS > 1) ? $clog2(BLINK_HALF_TICKS) : 1;
    localparam int unsigned STR_W = (STRETCH_TICKS > 0) ? $clog2(STRETCH_TICKS + 1) : 1;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_ON      = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_STRETCH = 2'b11;

    if (DIV < 2) begin : g_div_chk
        $error("mcoi_led_driver: CLK_FREQ_HZ/TICK_HZ must be at least 2");
    end
    if (NUM_LEDS < 1 || NUM_LEDS > 32) begin : g_num_chk
        $error("mcoi_led_driver: NUM_LEDS must be within 1..32");
    end
    if (BLINK_HALF_TICKS < 1 || STRETCH_TICKS < 1) begin : g_ticks_chk
        $error("mcoi_led_driver: BLINK_HALF_TICKS and STRETCH_TICKS must be at least 1");
    end

    logic [PRE_W-1:0]    pre_cnt_r;
    logic                tick_r;
    logic                tick_s;
    logic [BLK_W-1:0]    blink_cnt_r;
    logic [BLK_W-1:0]    blink_cnt_nxt_s;
    logic                blink_ph_r;
    logic                blink_ph_nxt_s;
    logic [NUM_LEDS-1:0] event_q_r;
    logic [NUM_LEDS-1:0] rise_s;
    logic [STR_W-1:0]    str_cnt_r   [NUM_LEDS];
    logic [STR_W-1:0]    str_nxt_s   [NUM_LEDS];
    logic [NUM_LEDS-1:0] sel_s;
    logic [NUM_LEDS-1:0] led_r;

    assign tick_s = (pre_cnt_r == PRE_W'(DIV - 1));
    assign rise_s = event_i & ~event_q_r;
    assign tick_o = tick_r;
    assign led_o  = led_r;

    // Prescaler counter and registered one-cycle tick pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_cnt_r <= {PRE_W{1'b0}};
            tick_r    <= 1'b0;
        end else begin
            tick_r    <= tick_s;
            pre_cnt_r <= tick_s ? {PRE_W{1'b0}} : (pre_cnt_r + PRE_W'(1));
        end
    end

    // Blink half-period counter; phase flips when the counter wraps on a tick.
    always_comb begin
        blink_cnt_nxt_s = blink_cnt_r;
        blink_ph_nxt_s  = blink_ph_r;
        if (tick_s) begin
            if (blink_cnt_r == BLK_W'(BLINK_HALF_TICKS - 1)) begin
                blink_cnt_nxt_s = {BLK_W{1'b0}};
                blink_ph_nxt_s  = ~blink_ph_r;
            end else begin
                blink_cnt_nxt_s = blink_cnt_r + BLK_W'(1);
                blink_ph_nxt_s  = blink_ph_r;
            end
        end else begin
            blink_cnt_nxt_s = blink_cnt_r;
            blink_ph_nxt_s  = blink_ph_r;
        end
    end

    // Blink state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blink_cnt_r <= {BLK_W{1'b0}};
            blink_ph_r  <= 1'b0;
        end else begin
            blink_cnt_r <= blink_cnt_nxt_s;
            blink_ph_r  <= blink_ph_nxt_s;
        end
    end

    // Stretch counters: a rising event reloads and wins over a same-cycle tick decrement.
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            str_nxt_s[i] = str_cnt_r[i];
            if (mode_ib[2*i +: 2] != MODE_STRETCH) begin
                str_nxt_s[i] = {STR_W{1'b0}};
            end else if (rise_s[i]) begin
                str_nxt_s[i] = STR_W'(STRETCH_TICKS);
            end else if (tick_s && (str_cnt_r[i] != {STR_W{1'b0}})) begin
                str_nxt_s[i] = str_cnt_r[i] - STR_W'(1);
            end else begin
                str_nxt_s[i] = str_cnt_r[i];
            end
        end
    end

    // Event edge-detect history and stretch counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            event_q_r <= {NUM_LEDS{1'b0}};
            for (int i = 0; i < NUM_LEDS; i++) begin
                str_cnt_r[i] <= {STR_W{1'b0}};
            end
        end else begin
            event_q_r <= event_i;
            for (int i = 0; i < NUM_LEDS; i++) begin
                str_cnt_r[i] <= str_nxt_s[i];
            end
        end
    end

    // Per-channel source select; blink uses the phase being loaded this edge so
    // the pin and the phase change together.
    always_comb begin
        sel_s = {NUM_LEDS{1'b0}};
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode_ib[2*i +: 2])
                MODE_OFF:     sel_s[i] = 1'b0;
                MODE_ON:      sel_s[i] = 1'b1;
                MODE_BLINK:   sel_s[i] = blink_ph_nxt_s;
                MODE_STRETCH: sel_s[i] = (str_cnt_r[i] != {STR_W{1'b0}});
                default:      sel_s[i] = 1'b0;
            endcase
        end
    end

    // Registered LED pins with optional active-low polarity.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_r <= {NUM_LEDS{INVERT}};
        end else begin
            led_r <= sel_s ^ {NUM_LEDS{INVERT}};
        end
    end

endmodule

// File: tb/tb_mcoi_led_driver.sv
// Scoreboard bench for mcoi_led_driver with DIV=10, 3-tick blink half period and
// 4-tick stretch; a second instance with INVERT=1 shares all inputs.
module tb_mcoi_led_driver;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [5:0] mode_ib = 6'b000000;
    logic [2:0] event_i = 3'b000;
    logic [2:0] led_o;
    logic       tick_o;
    logic [2:0] led_inv;
    logic       tick_inv;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    logic [3:0] exp_q [$];

    mcoi_led_driver #(
        .NUM_LEDS(3), .CLK_FREQ_HZ(1000), .TICK_HZ(100),
        .BLINK_HALF_TICKS(3), .STRETCH_TICKS(4), .INVERT(1'b0)
    ) dut (
        .clk(clk), .rstn(rstn), .mode_ib(mode_ib), .event_i(event_i),
        .led_o(led_o), .tick_o(tick_o)
    );

    mcoi_led_driver #(
        .NUM_LEDS(3), .CLK_FREQ_HZ(1000), .TICK_HZ(100),
        .BLINK_HALF_TICKS(3), .STRETCH_TICKS(4), .INVERT(1'b1)
    ) dut_inv (
        .clk(clk), .rstn(rstn), .mode_ib(mode_ib), .event_i(event_i),
        .led_o(led_inv), .tick_o(tick_inv)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc_n);
        $fatal(1, "bench time limit expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic apply_reset(input logic [5:0] mode);
        @(posedge clk);
        #1;
        rstn    = 1'b0;
        event_i = 3'b000;
        mode_ib = mode;
        @(posedge clk);
        #1;
        rstn  = 1'b1;
        cyc_n = 0;
    endtask

    // Stretch scenario tables indexed by the clock edge number after reset release.
    function automatic logic stretch_event(input int n);
        return (n == 13) || (n == 40) || (n >= 103 && n <= 302) ||
               (n == 320) || (n == 403) || (n == 413);
    endfunction

    function automatic logic [1:0] stretch_mode(input int n);
        return (n >= 411 && n <= 415) ? 2'b00 : 2'b11;
    endfunction

    function automatic logic stretch_led(input int n);
        return (n >= 14 && n <= 80) || (n >= 104 && n <= 140) ||
               (n >= 321 && n <= 360) || (n >= 404 && n <= 410);
    endfunction

    task automatic test_reset();
        logic [3:0] exp;
        rstn    = 1'b0;
        mode_ib = 6'b010101;
        event_i = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({tick_o, led_o, led_inv} !== 7'b0_000_111) begin
            bad++;
            $display("FAIL reset_state tick=%b led=%b led_inv=%b expected 0 000 111", tick_o, led_o, led_inv);
        end
        mode_ib = 6'b000000;
        rstn    = 1'b1;
        cyc_n   = 0;
        for (int k = 0; k < 100; k++) begin
            exp_q.push_back({((cyc_n + 1) % 10 == 0), 3'b000});
            step();
            exp = exp_q.pop_front();
            total++;
            if ({tick_o, led_o} !== exp || tick_inv !== exp[3]) begin
                bad++;
                $display("FAIL tick_period cyc=%0d got tick=%b led=%b tick_inv=%b expected %b", cyc_n, tick_o, led_o, tick_inv, exp);
            end
        end
    endtask

    task automatic test_static();
        logic [5:0] modes [4];
        logic [2:0] leds  [4];
        logic [3:0] exp;
        modes = '{6'b010001, 6'b111111, 6'b010101, 6'b000000};
        leds  = '{3'b101, 3'b000, 3'b111, 3'b000};
        for (int j = 0; j < 4; j++) begin
            mode_ib = modes[j];
            exp_q.push_back({((cyc_n + 1) % 10 == 0), leds[j]});
            step();
            exp = exp_q.pop_front();
            total++;
            if ({tick_o, led_o} !== exp || led_inv !== ~exp[2:0]) begin
                bad++;
                $display("FAIL static_mode mode=%b got led=%b led_inv=%b tick=%b expected %b", modes[j], led_o, led_inv, tick_o, exp);
            end
        end
    endtask

    task automatic test_stretch();
        logic [3:0] exp;
        apply_reset(6'b000011);
        for (int k = 0; k < 100; k++) begin
            event_i = {2'b00, stretch_event(cyc_n + 1)};
            mode_ib = {4'b0000, stretch_mode(cyc_n + 1)};
            exp_q.push_back({((cyc_n + 1) % 10 == 0), 2'b00, stretch_led(cyc_n + 1)});
            step();
            exp = exp_q.pop_front();
            total++;
            if ({tick_o, led_o} !== exp || led_inv !== ~exp[2:0]) begin
                bad++;
                $display("FAIL stretch_retrigger cyc=%0d got tick=%b led=%b expected %b", cyc_n, tick_o, led_o, exp);
            end
        end
    endtask

    task automatic test_event_held_tick();
        logic [3:0] exp;
        for (int k = 0; k < 270; k++) begin
            event_i = {2'b00, stretch_event(cyc_n + 1)};
            mode_ib = {4'b0000, stretch_mode(cyc_n + 1)};
            exp_q.push_back({((cyc_n + 1) % 10 == 0), 2'b00, stretch_led(cyc_n + 1)});
            step();
            exp = exp_q.pop_front();
            total++;
            if ({tick_o, led_o} !== exp) begin
                bad++;
                $display("FAIL event_held_tick cyc=%0d got tick=%b led=%b expected %b", cyc_n, tick_o, led_o, exp);
            end
        end
    endtask

    task automatic test_mode_change();
        logic [3:0] exp;
        for (int k = 0; k < 90; k++) begin
            event_i = {2'b00, stretch_event(cyc_n + 1)};
            mode_ib = {4'b0000, stretch_mode(cyc_n + 1)};
            exp_q.push_back({((cyc_n + 1) % 10 == 0), 2'b00, stretch_led(cyc_n + 1)});
            step();
            exp = exp_q.pop_front();
            total++;
            if ({tick_o, led_o} !== exp) begin
                bad++;
                $display("FAIL mode_change cyc=%0d got tick=%b led=%b expected %b", cyc_n, tick_o, led_o, exp);
            end
        end
        event_i = 3'b000;
    endtask

    task automatic test_blink_and_reset();
        logic [3:0] exp;
        apply_reset(6'b101010);
        for (int k = 0; k < 100; k++) begin
            exp_q.push_back({((cyc_n + 1) % 10 == 0), ((((cyc_n + 1) / 30) % 2) == 1) ? 3'b111 : 3'b000});
            step();
            exp = exp_q.pop_front();
            total++;
            if ({tick_o, led_o} !== exp || led_inv !== ~exp[2:0]) begin
                bad++;
                $display("FAIL blink cyc=%0d got tick=%b led=%b led_inv=%b expected %b", cyc_n, tick_o, led_o, led_inv, exp);
            end
        end
        // Asynchronous reset between edges while the blink phase is high.
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if ({tick_o, led_o, led_inv} !== 7'b0_000_111) begin
            bad++;
            $display("FAIL reset_mid_blink tick=%b led=%b led_inv=%b expected 0 000 111", tick_o, led_o, led_inv);
        end
        step();
        step();
        total++;
        if ({tick_o, led_o, led_inv} !== 7'b0_000_111) begin
            bad++;
            $display("FAIL reset_held tick=%b led=%b led_inv=%b expected 0 000 111", tick_o, led_o, led_inv);
        end
        rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_static();
        test_stretch();
        test_event_held_tick();
        test_mode_change();
        test_blink_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
